// File: rtl/segre_icache_refill.sv
// rtl/segre_icache_refill.sv - instruction-cache miss refill responder with true-LRU victim selection
module segre_icache_refill #(
    parameter int ADDR_SIZE         = 32,
    parameter int ICACHE_LANE_SIZE  = 128,
    parameter int ICACHE_INDEX_SIZE = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ic_access_i,
    input  logic                         ic_miss_i,
    input  logic [ADDR_SIZE-1:0]         ic_addr_i,
    output logic                         mmu_data_o,
    output logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o,
    output logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o,
    output logic                         mem_req_o,
    output logic [ADDR_SIZE-1:0]         mem_addr_o,
    input  logic                         mem_valid_i,
    input  logic [31:0]                  mem_rdata_i,
    output logic                         refill_busy_o
);

    localparam int NUM_LINES  = 2 ** ICACHE_INDEX_SIZE;
    localparam int BEATS      = ICACHE_LANE_SIZE / 32;
    localparam int LANE_BYTES = ICACHE_LANE_SIZE / 8;
    localparam int OFFS       = $clog2(LANE_BYTES);
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [ADDR_SIZE-1:0]         addr_q;
    logic [BEAT_W-1:0]            beat;
    logic [ICACHE_LANE_SIZE-1:0]  lane;
    logic [ICACHE_INDEX_SIZE-1:0] victim;
    logic [ICACHE_INDEX_SIZE-1:0] age [NUM_LINES];

    logic                         accept_miss;
    logic                         beat_done;
    logic                         last_beat;
    logic [ICACHE_INDEX_SIZE-1:0] oldest;
    logic                         touch_en;
    logic [ICACHE_INDEX_SIZE-1:0] touch_way;

    always_comb begin
        accept_miss = (state == IDLE) && ic_access_i && ic_miss_i;
        beat_done   = (state == FILL) && mem_valid_i;
        last_beat   = (beat == BEAT_W'(BEATS - 1));

        // Ages are a permutation, so exactly one way carries the maximum age.
        oldest = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (age[i] == ICACHE_INDEX_SIZE'(NUM_LINES - 1)) begin
                oldest = ICACHE_INDEX_SIZE'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        touch_en   = 1'b0;
        touch_way  = victim;
        case (state)
            IDLE: begin
                if (accept_miss) begin
                    state_next = FILL;
                end else if (ic_access_i && !ic_miss_i) begin
                    touch_en  = 1'b1;
                    touch_way = ic_addr_i[ICACHE_INDEX_SIZE-1:0];
                end
            end
            FILL: begin
                if (beat_done && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                touch_en   = 1'b1;
                touch_way  = victim;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            addr_q <= '0;
            beat   <= '0;
            lane   <= '0;
            victim <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                age[i] <= ICACHE_INDEX_SIZE'(NUM_LINES - 1 - i);
            end
        end else begin
            state <= state_next;
            if (accept_miss) begin
                addr_q <= {ic_addr_i[ADDR_SIZE-1:OFFS], {OFFS{1'b0}}};
                beat   <= '0;
                victim <= oldest;
            end
            if (beat_done) begin
                lane[32*beat +: 32] <= mem_rdata_i;
                if (last_beat) begin
                    beat <= '0;
                end else begin
                    beat   <= beat + 1'b1;
                    addr_q <= addr_q + ADDR_SIZE'(4);
                end
            end
            // Ways younger than the touched one age by one; the touched way becomes youngest.
            if (touch_en) begin
                for (int i = 0; i < NUM_LINES; i++) begin
                    if (ICACHE_INDEX_SIZE'(i) == touch_way) begin
                        age[i] <= '0;
                    end else if (age[i] < age[touch_way]) begin
                        age[i] <= age[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign mmu_data_o      = (state == DONE);
    assign mmu_wr_data_o   = lane;
    assign mmu_lru_index_o = victim;
    assign mem_req_o       = (state == FILL);
    assign mem_addr_o      = addr_q;
    assign refill_busy_o   = (state != IDLE);

endmodule

// File: tb/tb_segre_icache_refill.sv
// tb/tb_segre_icache_refill.sv - directed bench for segre_icache_refill
module tb_segre_icache_refill;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_access;
    logic         ic_miss;
    logic [31:0]  ic_addr;
    logic         mmu_data;
    logic [127:0] mmu_wr_data;
    logic [1:0]   mmu_lru_index;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_valid;
    logic [31:0]  mem_rdata;
    logic         refill_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    segre_icache_refill dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ic_access_i     (ic_access),
        .ic_miss_i       (ic_miss),
        .ic_addr_i       (ic_addr),
        .mmu_data_o      (mmu_data),
        .mmu_wr_data_o   (mmu_wr_data),
        .mmu_lru_index_o (mmu_lru_index),
        .mem_req_o       (mem_req),
        .mem_addr_o      (mem_addr),
        .mem_valid_i     (mem_valid),
        .mem_rdata_i     (mem_rdata),
        .refill_busy_o   (refill_busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_mmu_data", 128'(mmu_data), 128'(0));
        check("rst_wr_data", mmu_wr_data, 128'(0));
        check("rst_index", 128'(mmu_lru_index), 128'(0));
        check("rst_req", 128'(mem_req), 128'(0));
        check("rst_addr", 128'(mem_addr), 128'(0));
        check("rst_busy", 128'(refill_busy), 128'(0));
    endtask

    task automatic do_hit(input logic [1:0] way);
        ic_access = 1'b1;
        ic_miss   = 1'b0;
        ic_addr   = {30'd0, way};
        step();
        ic_access = 1'b0;
        check("hit_busy", 128'(refill_busy), 128'(0));
    endtask

    // Miss sampled in cycle 0; beats presented from cycle 1; optional stall before one beat.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] d0, input logic [1:0] exp_victim,
                           input int wait_beat, input int wait_n, input bit inject);
        logic [31:0]  base;
        logic [127:0] lane;
        base = {addr[31:4], 4'h0};
        lane = '0;
        ic_access = 1'b1;
        ic_miss   = 1'b1;
        ic_addr   = addr;
        step();
        ic_access = 1'b0;
        ic_miss   = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == wait_beat) begin
                for (int k = 0; k < wait_n; k++) begin
                    check("wait_req", 128'(mem_req), 128'(1));
                    check("wait_addr", 128'(mem_addr), 128'(base + 32'(4 * b)));
                    step();
                end
            end
            check("beat_req", 128'(mem_req), 128'(1));
            check("beat_addr", 128'(mem_addr), 128'(base + 32'(4 * b)));
            check("no_early_pulse", 128'(mmu_data), 128'(0));
            if (inject && b == 1) begin
                ic_access = 1'b1;
                ic_miss   = 1'b1;
                ic_addr   = 32'h0000_8000;
            end
            mem_valid = 1'b1;
            mem_rdata = d0 + 32'(b);
            lane[32*b +: 32] = d0 + 32'(b);
            step();
            mem_valid = 1'b0;
            ic_access = 1'b0;
            ic_miss   = 1'b0;
        end
        check("pulse", 128'(mmu_data), 128'(1));
        check("lane", mmu_wr_data, lane);
        check("victim", 128'(mmu_lru_index), 128'(exp_victim));
        check("done_req", 128'(mem_req), 128'(0));
        check("done_busy", 128'(refill_busy), 128'(1));
        step();
        check("pulse_end", 128'(mmu_data), 128'(0));
        check("back_idle", 128'(refill_busy), 128'(0));
    endtask

    initial begin
        rst       = 1'b1;
        ic_access = 1'b0;
        ic_miss   = 1'b0;
        ic_addr   = '0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        step();
        step();
        check_reset_outputs();
        rst = 1'b0;
        step();

        // First miss: lane 0x000000A3_000000A2_000000A1_000000A0 into way 0.
        do_miss(32'h0000_1234, 32'h0000_00A0, 2'd0, -1, 0, 1'b0);
        do_miss(32'h0000_2000, 32'h0000_0100, 2'd1, -1, 0, 1'b0);
        do_miss(32'h0000_3010, 32'h0000_0200, 2'd2, -1, 0, 1'b0);
        do_miss(32'hFFFF_FFFC, 32'h0000_0300, 2'd3, -1, 0, 1'b0);

        do_hit(2'd0);
        do_miss(32'h0000_4000, 32'h0000_0400, 2'd1, -1, 0, 1'b0);

        // LRU order now 2,3,0,1: stall before beat 2 pushes the pulse to cycle 8.
        do_miss(32'h0000_5008, 32'h0000_0500, 2'd2, 2, 3, 1'b0);

        // A miss report while filling must not disturb the refill in flight.
        do_miss(32'h0000_6004, 32'h0000_0600, 2'd3, -1, 0, 1'b1);
        step();
        check("inject_no_second_pulse", 128'(mmu_data), 128'(0));
        check("inject_stays_idle", 128'(refill_busy), 128'(0));

        // Reset during beat 1 of a refill.
        ic_access = 1'b1;
        ic_miss   = 1'b1;
        ic_addr   = 32'h0000_7000;
        step();
        ic_access = 1'b0;
        ic_miss   = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 32'h0000_0055;
        step();
        check("pre_rst_addr", 128'(mem_addr), 128'h7004);
        rst       = 1'b1;
        mem_rdata = 32'h0000_0066;
        step();
        rst       = 1'b0;
        mem_valid = 1'b0;
        check_reset_outputs();
        step();
        check("post_rst_no_pulse", 128'(mmu_data), 128'(0));

        do_miss(32'h0000_9008, 32'h0000_0900, 2'd0, -1, 0, 1'b0);
        do_miss(32'h0000_A000, 32'h0000_0A00, 2'd1, -1, 0, 1'b0);
        do_miss(32'h0000_B000, 32'h0000_0B00, 2'd2, -1, 0, 1'b0);
        do_miss(32'h0000_C000, 32'h0000_0C00, 2'd3, -1, 0, 1'b0);
        do_miss(32'h0000_D000, 32'h0000_0D00, 2'd0, -1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
